// File: rtl/branch_pc_ctrl_pkg.sv
// branch_pc_ctrl_pkg
//   Shared definitions for the fetch-stage branch/PC control block:
//   - PCMUX_* next-PC select codes, shared with the next-PC mux.
//   - 2-bit saturating counter type, its bounds, reset and allocate values.
//   - ctr_next(): one saturating step of a direction counter.
package branch_pc_ctrl_pkg;

    // Next-PC mux select codes
    localparam logic [2:0] PCMUX_CURR_PC4 = 3'd0;
    localparam logic [2:0] PCMUX_HAZARD   = 3'd1;
    localparam logic [2:0] PCMUX_BRANCH   = 3'd2;
    localparam logic [2:0] PCMUX_CORR_PC4 = 3'd3;
    localparam logic [2:0] PCMUX_PRED_TGT = 3'd4;

    // Direction counter: MSB set means "predict taken"
    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_MIN   = 2'b00;
    localparam ctr_t CTR_MAX   = 2'b11;
    localparam ctr_t CTR_RESET = 2'b01;   // weakly not-taken
    localparam ctr_t CTR_ALLOC = 2'b10;   // weakly taken, on first taken resolve

    // Saturating increment on taken, decrement on not taken
    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        ctr_t r;
        r = c;
        if (taken) begin
            if (c != CTR_MAX) r = c + 2'd1;
        end else begin
            if (c != CTR_MIN) r = c - 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/branch_pc_ctrl_btb_store.sv
// branch_pc_ctrl_btb_store
//   Direct-mapped BTB storage: valid, tag, target and 2-bit counter arrays.
//   Ports:
//     clk, rst                   clock, async active-high reset
//     rd_idx_i, rd_tag_i         lookup index/tag (fetch PC)
//     rd_hit_o                   entry valid and tag matches
//     rd_taken_o                 counter MSB of the indexed entry
//     rd_tgt_o                   stored target of the indexed entry
//     wr_en_i                    a resolved control-flow instruction updates the BTB
//     wr_idx_i, wr_tag_i         update index/tag (EX PC)
//     wr_taken_i, wr_target_i    resolved direction and target
//   Reads are purely combinational on the current array contents, so a
//   same-cycle update to the read index is not visible until the next cycle.
module branch_pc_ctrl_btb_store
    import branch_pc_ctrl_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int TAG_W   = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic [TAG_W-1:0] rd_tag_i,
    output logic             rd_hit_o,
    output logic             rd_taken_o,
    output logic [31:0]      rd_tgt_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic             wr_taken_i,
    input  logic [31:0]      wr_target_i
);

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [31:0]      tgt_q   [ENTRIES];
    ctr_t             ctr_q   [ENTRIES];

    logic wr_hit;

    assign rd_hit_o   = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    assign rd_taken_o = ctr_q[rd_idx_i][1];
    assign rd_tgt_o   = tgt_q[rd_idx_i];

    assign wr_hit = valid_q[wr_idx_i] && (tag_q[wr_idx_i] == wr_tag_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= CTR_RESET;
            end
        end else if (wr_en_i) begin
            if (wr_hit) begin
                ctr_q[wr_idx_i] <= ctr_next(ctr_q[wr_idx_i], wr_taken_i);
                if (wr_taken_i) tgt_q[wr_idx_i] <= wr_target_i;
            end else if (wr_taken_i) begin
                // Allocate (or evict an aliasing entry) only for taken flow;
                // a not-taken miss carries no useful target.
                valid_q[wr_idx_i] <= 1'b1;
                tag_q[wr_idx_i]   <= wr_tag_i;
                tgt_q[wr_idx_i]   <= wr_target_i;
                ctr_q[wr_idx_i]   <= CTR_ALLOC;
            end
        end
    end

endmodule

// File: rtl/branch_pc_ctrl.sv
// branch_pc_ctrl
//   Fetch-stage next-PC control: BTB lookup on the fetch PC, mispredict
//   detection on the branch resolved in EX, next-PC select, flush and
//   performance counters.
//   Ports:
//     clk, rst          clock, async active-high reset
//     if_pc             fetch PC (lookup)
//     stall             load-use hazard; hold the PC
//     ex_valid          control-flow instruction resolved in EX this cycle
//     ex_pc             its PC
//     ex_taken          actual direction (1 for jumps)
//     ex_target         actual target
//     ex_pred_taken     prediction made at fetch for it
//     ex_pred_target    predicted target made at fetch for it
//     pc_sel            next-PC mux select (PCMUX_* codes)
//     predicted_target  BTB target for if_pc (0 on miss)
//     pred_taken        BTB direction for if_pc
//     corr_pc4          ex_pc + 4 for not-taken recovery
//     flush             kill IF/ID and ID/EX on a mispredict
//     br_count          resolved control-flow instructions
//     mispred_count     mispredicts
//   All outputs are forced to their idle values while rst is high.
module branch_pc_ctrl #(
    parameter int BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic [2:0]  pc_sel,
    output logic [31:0] predicted_target,
    output logic        pred_taken,
    output logic [31:0] corr_pc4,
    output logic        flush,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);
    import branch_pc_ctrl_pkg::*;

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0] rd_tag, wr_tag;
    logic             rd_hit, rd_taken;
    logic [31:0]      rd_tgt;
    logic             mis;
    logic [31:0]      br_count_q, br_count_d;
    logic [31:0]      mispred_count_q, mispred_count_d;
    logic             unused_pc_lsbs;

    // Instructions are word aligned; the byte offset never indexes the BTB.
    assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

    assign rd_idx = if_pc[IDX_W+1:2];
    assign rd_tag = if_pc[31:IDX_W+2];
    assign wr_idx = ex_pc[IDX_W+1:2];
    assign wr_tag = ex_pc[31:IDX_W+2];

    branch_pc_ctrl_btb_store #(
        .ENTRIES (BTB_ENTRIES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) u_btb_store (
        .clk         (clk),
        .rst         (rst),
        .rd_idx_i    (rd_idx),
        .rd_tag_i    (rd_tag),
        .rd_hit_o    (rd_hit),
        .rd_taken_o  (rd_taken),
        .rd_tgt_o    (rd_tgt),
        .wr_en_i     (ex_valid),
        .wr_idx_i    (wr_idx),
        .wr_tag_i    (wr_tag),
        .wr_taken_i  (ex_taken),
        .wr_target_i (ex_target)
    );

    // Target only matters when the branch was actually taken.
    assign mis = ex_valid &&
                 ((ex_taken != ex_pred_taken) ||
                  (ex_taken && (ex_target != ex_pred_target)));

    assign pred_taken       = !rst && rd_hit && rd_taken;
    assign predicted_target = (!rst && rd_hit) ? rd_tgt : 32'd0;
    assign corr_pc4         = rst ? 32'd0 : ex_pc + 32'd4;
    assign flush            = !rst && mis;

    // A mispredict outranks stall: the stalled instruction is wrong-path.
    always_comb begin
        pc_sel = PCMUX_CURR_PC4;
        if (!rst) begin
            if (mis && ex_taken)       pc_sel = PCMUX_BRANCH;
            else if (mis)              pc_sel = PCMUX_CORR_PC4;
            else if (stall)            pc_sel = PCMUX_HAZARD;
            else if (rd_hit && rd_taken) pc_sel = PCMUX_PRED_TGT;
        end
    end

    always_comb begin
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (ex_valid) br_count_d      = br_count_q + 32'd1;
        if (mis)      mispred_count_d = mispred_count_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count_q      <= 32'd0;
            mispred_count_q <= 32'd0;
        end else begin
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_pc_ctrl.sv
module tb_branch_pc_ctrl;
  import branch_pc_ctrl_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [2:0]  pc_sel;
  logic [31:0] predicted_target;
  logic        pred_taken;
  logic [31:0] corr_pc4;
  logic        flush;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  always #5 clk = ~clk;

  branch_pc_ctrl #(.BTB_ENTRIES(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .if_pc            (if_pc),
    .stall            (stall),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .pc_sel           (pc_sel),
    .predicted_target (predicted_target),
    .pred_taken       (pred_taken),
    .corr_pc4         (corr_pc4),
    .flush            (flush),
    .br_count         (br_count),
    .mispred_count    (mispred_count)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [36:0] exp_q[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] ipc, input logic st, input logic v,
                       input logic [31:0] epc, input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt);
    if_pc          = ipc;
    stall          = st;
    ex_valid       = v;
    ex_pc          = epc;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] ipc;
    logic        st;
    logic        v;
    logic [31:0] epc;
    logic        tk;
    logic [31:0] tgt;
    logic        ptk;
    logic [31:0] ptgt;
    logic [2:0]  e_sel;
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic        e_flush;
    logic [31:0] e_br;
    logic [31:0] e_mis;
  } vec_t;

  localparam logic [31:0] Z = 32'h0;
  localparam logic O = 1'b1;
  localparam logic N = 1'b0;

  vec_t vecs[21];

  // ---------------- reference model ----------------
  typedef struct {
    bit          v;
    int unsigned tag;
    logic [31:0] tgt;
    int          str;   // confidence 0..3, predicts taken at 2 or more
  } ment_t;

  ment_t       m[16];
  int unsigned m_br, m_mis;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m[i].v = 0; m[i].tag = 0; m[i].tgt = 32'h0; m[i].str = 1;
    end
    m_br = 0; m_mis = 0;
  endtask

  // random-phase locals
  logic [31:0] r_ipc, r_epc, r_tgt, r_ptgt, e_ptgt;
  logic        r_st, r_v, r_tk, r_ptk, e_pt, e_mis, m_hit;
  logic [2:0]  e_sel;
  logic [36:0] e;
  int unsigned li, lt, ui, ut;

  initial begin
    // ---------------- reset ----------------
    rst = 1'b1;
    drive(32'h100, N, O, 32'h100, O, 32'h200, N, Z);
    #3;
    check32("rst_pc_sel", {29'd0, pc_sel}, {29'd0, PCMUX_CURR_PC4});
    check32("rst_flush", {31'd0, flush}, 32'd0);
    check32("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    check32("rst_corr_pc4", corr_pc4, 32'd0);
    check32("rst_br_count", br_count, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    drive(32'h100, N, N, Z, N, Z, N, Z);
    next_cycle();

    // ipc st v epc tk tgt ptk ptgt | sel pt ptgt flush br mis
    vecs[0]  = '{32'h100, N, N, Z,       N, Z,       N, Z,       PCMUX_CURR_PC4, N, Z,       N, 32'd0,  32'd0};
    vecs[1]  = '{32'h100, N, O, 32'h100, O, 32'h200, N, Z,       PCMUX_BRANCH,   N, Z,       O, 32'd0,  32'd0};
    vecs[2]  = '{32'h100, N, N, Z,       N, Z,       N, Z,       PCMUX_PRED_TGT, O, 32'h200, N, 32'd1,  32'd1};
    vecs[3]  = '{32'h100, N, O, 32'h100, O, 32'h200, O, 32'h200, PCMUX_PRED_TGT, O, 32'h200, N, 32'd1,  32'd1};
    vecs[4]  = '{32'h100, N, O, 32'h100, O, 32'h200, O, 32'h200, PCMUX_PRED_TGT, O, 32'h200, N, 32'd2,  32'd1};
    vecs[5]  = '{32'h100, N, O, 32'h100, N, 32'h104, O, 32'h200, PCMUX_CORR_PC4, O, 32'h200, O, 32'd3,  32'd1};
    vecs[6]  = '{32'h100, N, N, Z,       N, Z,       N, Z,       PCMUX_PRED_TGT, O, 32'h200, N, 32'd4,  32'd2};
    vecs[7]  = '{32'h100, N, O, 32'h100, N, 32'h104, O, 32'h200, PCMUX_CORR_PC4, O, 32'h200, O, 32'd4,  32'd2};
    vecs[8]  = '{32'h100, N, N, Z,       N, Z,       N, Z,       PCMUX_CURR_PC4, N, 32'h200, N, 32'd5,  32'd3};
    vecs[9]  = '{32'h100, N, O, 32'h100, O, 32'h200, N, Z,       PCMUX_BRANCH,   N, 32'h200, O, 32'd5,  32'd3};
    vecs[10] = '{32'h100, N, O, 32'h100, O, 32'h300, O, 32'h200, PCMUX_BRANCH,   O, 32'h200, O, 32'd6,  32'd4};
    vecs[11] = '{32'h100, N, N, Z,       N, Z,       N, Z,       PCMUX_PRED_TGT, O, 32'h300, N, 32'd7,  32'd5};
    vecs[12] = '{32'h100, O, N, Z,       N, Z,       N, Z,       PCMUX_HAZARD,   O, 32'h300, N, 32'd7,  32'd5};
    vecs[13] = '{32'h100, O, O, 32'h184, O, 32'h400, N, Z,       PCMUX_BRANCH,   O, 32'h300, O, 32'd7,  32'd5};
    vecs[14] = '{32'h140, N, N, Z,       N, Z,       N, Z,       PCMUX_CURR_PC4, N, Z,       N, 32'd8,  32'd6};
    vecs[15] = '{32'h100, N, O, 32'h140, O, 32'h500, N, Z,       PCMUX_BRANCH,   O, 32'h300, O, 32'd8,  32'd6};
    vecs[16] = '{32'h100, N, N, Z,       N, Z,       N, Z,       PCMUX_CURR_PC4, N, Z,       N, 32'd9,  32'd7};
    vecs[17] = '{32'h140, N, N, Z,       N, Z,       N, Z,       PCMUX_PRED_TGT, O, 32'h500, N, 32'd9,  32'd7};
    vecs[18] = '{32'h184, N, N, Z,       N, Z,       N, Z,       PCMUX_PRED_TGT, O, 32'h400, N, 32'd9,  32'd7};
    vecs[19] = '{32'h208, N, O, 32'h208, N, 32'h300, N, Z,       PCMUX_CURR_PC4, N, Z,       N, 32'd9,  32'd7};
    vecs[20] = '{32'h208, N, N, Z,       N, Z,       N, Z,       PCMUX_CURR_PC4, N, Z,       N, 32'd10, 32'd7};

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].ipc, vecs[i].st, vecs[i].v, vecs[i].epc, vecs[i].tk,
            vecs[i].tgt, vecs[i].ptk, vecs[i].ptgt);
      #1;
      check32($sformatf("vec%0d_pc_sel", i), {29'd0, pc_sel}, {29'd0, vecs[i].e_sel});
      check32($sformatf("vec%0d_pred_taken", i), {31'd0, pred_taken}, {31'd0, vecs[i].e_pt});
      check32($sformatf("vec%0d_pred_tgt", i), predicted_target, vecs[i].e_ptgt);
      check32($sformatf("vec%0d_flush", i), {31'd0, flush}, {31'd0, vecs[i].e_flush});
      check32($sformatf("vec%0d_corr_pc4", i), corr_pc4, vecs[i].epc + 32'd4);
      check32($sformatf("vec%0d_br_count", i), br_count, vecs[i].e_br);
      check32($sformatf("vec%0d_mis_count", i), mispred_count, vecs[i].e_mis);
      next_cycle();
    end

    // ---------------- asynchronous reset mid-cycle ----------------
    // 0x140 hits and a mispredict is in flight when rst rises between edges.
    drive(32'h140, N, O, 32'h184, O, 32'h900, N, Z);
    #2 rst = 1'b1;
    #1;
    check32("arst_pc_sel", {29'd0, pc_sel}, {29'd0, PCMUX_CURR_PC4});
    check32("arst_flush", {31'd0, flush}, 32'd0);
    check32("arst_pred_taken", {31'd0, pred_taken}, 32'd0);
    check32("arst_pred_tgt", predicted_target, 32'd0);
    check32("arst_corr_pc4", corr_pc4, 32'd0);
    check32("arst_br_count", br_count, 32'd0);
    check32("arst_mis_count", mispred_count, 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    drive(32'h140, N, N, Z, N, Z, N, Z);
    #1;
    check32("post_rst_pc_sel", {29'd0, pc_sel}, {29'd0, PCMUX_CURR_PC4});
    check32("post_rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    check32("post_rst_br_count", br_count, 32'd0);
    next_cycle();

    // ---------------- randomized phase against the model ----------------
    model_reset();
    for (int n = 0; n < 400; n++) begin
      r_ipc  = 32'($urandom_range(0, 255)) * 32'd4;
      r_st   = ($urandom_range(0, 3) == 0);
      r_v    = ($urandom_range(0, 1) == 1);
      r_epc  = 32'($urandom_range(0, 255)) * 32'd4;
      if ($urandom_range(0, 7) == 0) r_epc = 32'hFFFF_FFFC;
      r_tk   = ($urandom_range(0, 1) == 1);
      r_tgt  = $urandom & 32'hFFFF_FFFC;
      r_ptk  = ($urandom_range(0, 1) == 1);
      r_ptgt = ($urandom_range(0, 2) != 0) ? r_tgt : ($urandom & 32'hFFFF_FFFC);

      li     = (r_ipc / 4) % 16;
      lt     = r_ipc / 64;
      m_hit  = m[li].v && (m[li].tag == lt);
      e_pt   = m_hit && (m[li].str >= 2);
      e_ptgt = m_hit ? m[li].tgt : 32'h0;
      e_mis  = r_v && ((r_tk != r_ptk) || (r_tk && (r_tgt != r_ptgt)));
      if (e_mis && r_tk)  e_sel = PCMUX_BRANCH;
      else if (e_mis)     e_sel = PCMUX_CORR_PC4;
      else if (r_st)      e_sel = PCMUX_HAZARD;
      else if (e_pt)      e_sel = PCMUX_PRED_TGT;
      else                e_sel = PCMUX_CURR_PC4;
      exp_q.push_back({e_sel, e_pt, e_ptgt, e_mis});

      drive(r_ipc, r_st, r_v, r_epc, r_tk, r_tgt, r_ptk, r_ptgt);
      #1;
      e = exp_q.pop_front();
      check32("rnd_pc_sel", {29'd0, pc_sel}, {29'd0, e[36:34]});
      check32("rnd_pred_taken", {31'd0, pred_taken}, {31'd0, e[33]});
      check32("rnd_pred_tgt", predicted_target, e[32:1]);
      check32("rnd_flush", {31'd0, flush}, {31'd0, e[0]});
      check32("rnd_corr_pc4", corr_pc4, r_epc + 32'd4);
      check32("rnd_br_count", br_count, m_br);
      check32("rnd_mis_count", mispred_count, m_mis);

      if (r_v) begin
        ui = (r_epc / 4) % 16;
        ut = r_epc / 64;
        if (m[ui].v && m[ui].tag == ut) begin
          if (r_tk) begin
            m[ui].str = (m[ui].str + 1 > 3) ? 3 : m[ui].str + 1;
            m[ui].tgt = r_tgt;
          end else begin
            m[ui].str = (m[ui].str - 1 < 0) ? 0 : m[ui].str - 1;
          end
        end else if (r_tk) begin
          m[ui].v   = 1;
          m[ui].tag = ut;
          m[ui].tgt = r_tgt;
          m[ui].str = 2;
        end
        m_br++;
        if (e_mis) m_mis++;
      end
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_pc_ctrl.md
# branch_pc_ctrl

Generates the PC-select code and the predicted and corrected PC values that drive the fetch-stage next-PC multiplexer of the RV32I pipeline. It holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, looked up combinationally on the fetch PC. It checks branches resolved in EX against the prediction carried down the pipe, selects the recovery path and flushes wrong-path instructions on a mispredict. It also keeps branch and mispredict performance counters.

## Interface
- BTB_ENTRIES, 16: BTB depth; power of two, ≥ 2. IDX_W = log2(BTB_ENTRIES).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_pc  in  32  current fetch PC.
- stall  in  1  load-use hazard from the hazard unit; hold the PC.
- ex_valid  in  1  a control-flow instruction (branch, JAL or JALR) is resolved in EX this cycle.
- ex_pc  in  32  PC of the resolved instruction.
- ex_taken  in  1  actual direction; always 1 for jumps.
- ex_target  in  32  actual target, computed in EX.
- ex_pred_taken  in  1  prediction made at fetch, piped down with the instruction.
- ex_pred_target  in  32  predicted target, piped down with the instruction.
- pc_sel  out  3  next-PC select; uses the `PCMUX_*` codes.
- predicted_target  out  32  BTB target for if_pc.
- pred_taken  out  1  prediction for if_pc; goes into the IF/ID register.
- corr_pc4  out  32  ex_pc + 4, for not-taken recovery.
- flush  out  1  kill IF/ID and ID/EX contents.
- br_count  out  32  resolved control-flow instructions.
- mispred_count  out  32  mispredicts.

## Operation
- Lookup (combinational):
  - idx = if_pc[IDX_W+1:2]; tag = if_pc[31:IDX_W+2].
  - hit = valid[idx] && tag_q[idx] == tag.
  - pred_taken = hit && ctr[idx][1].
  - predicted_target = hit ? tgt[idx] : 0.
- Mispredict: mis = ex_valid && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target)).
- pc_sel priority, highest first:
  - mis && ex_taken → PCMUX_BRANCH.
  - mis && !ex_taken → PCMUX_CORR_PC4.
  - stall → PCMUX_HAZARD.
  - pred_taken → PCMUX_PRED_TGT.
  - otherwise PCMUX_CURR_PC4.
- flush = mis. A mispredict overrides stall, because the stalled instruction is on the wrong path.
- corr_pc4 = ex_pc + 4, modulo 2^32.
- BTB update on the clock edge when ex_valid, indexed and tagged by ex_pc:
  - Entry misses and the instruction was taken: allocate; valid=1, tag written, tgt=ex_target, ctr=2'b10.
  - Entry misses and the instruction was not taken: no change.
  - Entry hits: ctr saturating +1 if taken, −1 if not taken, floor 00 and ceiling 11; tgt=ex_target if taken.
- A lookup and an update to the same index in the same cycle: the lookup sees pre-update contents; no bypass.
- Counters:
  - br_count increments on ex_valid.
  - mispred_count increments on mis.
  - Both wrap at 2^32.

## Timing
- Lookup, pc_sel and flush are combinational, zero latency. They are valid in the same cycle as their inputs.
- A BTB update is visible to lookups from the cycle after the resolving edge.
- A resolved mispredict redirects fetch and asserts flush in that same cycle. flush lasts one cycle per mispredict.
- Back-to-back mispredicts in consecutive cycles are each handled independently.
- While rst is high:
  - all valid bits = 0, all ctr = 2'b01, br_count = 0, mispred_count = 0.
  - outputs forced: pc_sel = PCMUX_CURR_PC4, flush = 0, pred_taken = 0, predicted_target = 0, corr_pc4 = 0.
- Reset asserted mid-operation clears the state immediately, with no clock required. Normal operation resumes on the first edge after deassertion.

## Structure
- `PCMUX_*` codes live in defines.vh, shared with the next-PC mux: CURR_PC4=3'd0, HAZARD=3'd1, BRANCH=3'd2, CORR_PC4=3'd3, PRED_TGT=3'd4.
- Counter encoding and the reset counter value are also defined in defines.vh.
- One sub-module, btb_store: valid, tag, target and counter arrays, with a read port on the lookup index and a write port carrying the update logic.
- Selection, mispredict detection and performance counters stay in the top level.

## Test plan
- Reset: pulse rst asynchronously mid-cycle, then if_pc=0x100 → pc_sel=CURR_PC4, pred_taken=0, flush=0, both counts 0.
- Cold taken branch: ex_valid=1, ex_pc=0x100, ex_taken=1, ex_target=0x200, ex_pred_taken=0 → same cycle pc_sel=BRANCH, flush=1. Next cycle: mispred_count=1. Then if_pc=0x100 → pc_sel=PRED_TGT, predicted_target=0x200.
- Hysteresis: train 0x100 taken three times (ctr=11), then resolve not taken with ex_pred_taken=1 → pc_sel=CORR_PC4, corr_pc4=0x104; lookup still predicts taken. A second not-taken resolution → lookup of 0x100 gives pred_taken=0.
- Wrong target: predicted taken to 0x200, actual taken to 0x300 → pc_sel=BRANCH, flush=1. Next lookup of 0x100 gives predicted_target=0x300.
- Priority: stall=1 with a BTB hit → HAZARD. stall=1 with a taken mispredict in the same cycle → BRANCH, flush=1.
- Aliasing (BTB_ENTRIES=16): 0x100 allocated; lookup of 0x140, which shares the index with a different tag → pred_taken=0, pc_sel=CURR_PC4. Same-cycle update and lookup of index 0 → the old entry is returned.
